// File: rtl/conv25d_pkg.sv
// Shared widths, types and helpers for the 2.5D convolution stage.
package conv25d_pkg;

    localparam int unsigned PIXEL_W  = 8;
    localparam int unsigned WEIGHT_W = 8;
    localparam int unsigned ACC_W    = 32;

    typedef logic [PIXEL_W-1:0]  pixel_t;
    typedef logic [WEIGHT_W-1:0] weight_t;
    typedef logic [ACC_W-1:0]    acc_t;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned log2_ceil(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/conv25d_mult_adder_tree.sv
// One kernel/channel dot product: TREE_SIZE unsigned pixels times signed
// weights, registered products followed by a registered binary adder tree.
// Latency from inputs to sum: 1 + log2(TREE_SIZE) rising edges.
module conv25d_mult_adder_tree
    import conv25d_pkg::*;
#(
    parameter int unsigned TREE_SIZE = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [PIXEL_W*TREE_SIZE-1:0]  pixels,
    input  logic [WEIGHT_W*TREE_SIZE-1:0] weights,
    output logic [ACC_W-1:0]              sum
);

    // Heap layout: node i adds children 2i and 2i+1; leaves sit at
    // TREE_SIZE..2*TREE_SIZE-1, so every leaf has equal depth to node 1.
    acc_t products [TREE_SIZE];
    acc_t tree     [1:2*TREE_SIZE-1];

    // Products: pixel zero-extended, weight sign-extended, both to ACC_W.
    always_comb begin
        for (int unsigned i = 0; i < TREE_SIZE; i++) begin
            products[i] = ACC_W'($signed({1'b0, pixels[i*PIXEL_W +: PIXEL_W]}))
                        * ACC_W'($signed(weights[i*WEIGHT_W +: WEIGHT_W]));
        end
    end

    // Product register stage plus one adder level per cycle up to the root.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 1; i < 2*TREE_SIZE; i++) begin
                tree[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < TREE_SIZE; i++) begin
                tree[TREE_SIZE+i] <= products[i];
            end
            for (int unsigned i = 1; i < TREE_SIZE; i++) begin
                tree[i] <= tree[2*i] + tree[2*i+1];
            end
        end
    end

    assign sum = tree[1];

endmodule

// File: rtl/convolution_25d.sv
// 2.5D convolution stage: per-channel row-structured window shift register,
// NUM_TREES x Z_DEPTH multiply/adder trees, and a registered cross-channel
// adder tree per kernel. Fully pipelined, one window per cycle.
// Optional build macro CONV25D_RELU_EN clamps negative final sums to zero.
module convolution_25d
    import conv25d_pkg::*;
#(
    parameter int unsigned NUM_TREES    = 2,
    parameter int unsigned Z_DEPTH      = 4,
    parameter int unsigned P_SR_DEPTH   = 4,
    parameter int unsigned RAM_SR_DEPTH = 2,
    parameter int unsigned NUM_SR_ROWS  = 4,
    parameter int unsigned MA_TREE_SIZE = 16
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic [PIXEL_W*Z_DEPTH-1:0]                        pixel_vector_in,
    input  logic [WEIGHT_W*NUM_TREES*MA_TREE_SIZE*Z_DEPTH-1:0] kernel,
    output logic [ACC_W*NUM_TREES-1:0]                        pixel_vector_out
);

    localparam int unsigned ROW_LEN  = P_SR_DEPTH + RAM_SR_DEPTH;
    localparam int unsigned SR_LEN   = NUM_SR_ROWS*ROW_LEN - RAM_SR_DEPTH;
    localparam int unsigned Z_LEVELS = log2_ceil(Z_DEPTH);

    function automatic acc_t final_stage(input acc_t value);
`ifdef CONV25D_RELU_EN
        return value[ACC_W-1] ? '0 : value;
`else
        return value;
`endif
    endfunction

    pixel_t                          shift_reg   [Z_DEPTH][SR_LEN];
    logic [PIXEL_W*MA_TREE_SIZE-1:0] window      [Z_DEPTH];
    acc_t                            channel_sum [NUM_TREES][Z_DEPTH];

    // Shift each channel's newest pixel into its delay line every edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned z = 0; z < Z_DEPTH; z++) begin
                for (int unsigned k = 0; k < SR_LEN; k++) begin
                    shift_reg[z][k] <= '0;
                end
            end
        end else begin
            for (int unsigned z = 0; z < Z_DEPTH; z++) begin
                shift_reg[z][0] <= pixel_vector_in[z*PIXEL_W +: PIXEL_W];
                for (int unsigned k = 1; k < SR_LEN; k++) begin
                    shift_reg[z][k] <= shift_reg[z][k-1];
                end
            end
        end
    end

    for (genvar z = 0; z < Z_DEPTH; z++) begin : g_channel
        // Tap j skips the RAM_SR_DEPTH untapped samples between rows.
        for (genvar j = 0; j < MA_TREE_SIZE; j++) begin : g_tap
            localparam int unsigned TAP = (j / P_SR_DEPTH)*ROW_LEN + (j % P_SR_DEPTH);
            assign window[z][j*PIXEL_W +: PIXEL_W] = shift_reg[z][TAP];
        end

        for (genvar t = 0; t < NUM_TREES; t++) begin : g_kernel
            conv25d_mult_adder_tree #(
                .TREE_SIZE (MA_TREE_SIZE)
            ) u_mult_adder_tree (
                .clock   (clock),
                .reset   (reset),
                .pixels  (window[z]),
                .weights (kernel[((z*NUM_TREES + t)*MA_TREE_SIZE)*WEIGHT_W +: MA_TREE_SIZE*WEIGHT_W]),
                .sum     (channel_sum[t][z])
            );
        end
    end

    for (genvar t = 0; t < NUM_TREES; t++) begin : g_ztree
        if (Z_LEVELS == 0) begin : g_single
            // No cross-channel stage exists, so the clamp sits on the
            // channel tree's root register output; timing is unchanged.
            assign pixel_vector_out[t*ACC_W +: ACC_W] = final_stage(channel_sum[t][0]);
        end else begin : g_tree
            acc_t node    [1:Z_DEPTH-1];
            acc_t operand [1:2*Z_DEPTH-1];

            // Heap view of the tree: internal registers first, channel sums as leaves.
            always_comb begin
                for (int unsigned i = 1; i < Z_DEPTH; i++) begin
                    operand[i] = node[i];
                end
                for (int unsigned i = 0; i < Z_DEPTH; i++) begin
                    operand[Z_DEPTH+i] = channel_sum[t][i];
                end
            end

            // One registered adder level per cycle; the root applies the final clamp.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    for (int unsigned i = 1; i < Z_DEPTH; i++) begin
                        node[i] <= '0;
                    end
                end else begin
                    node[1] <= final_stage(operand[2] + operand[3]);
                    for (int unsigned i = 2; i < Z_DEPTH; i++) begin
                        node[i] <= operand[2*i] + operand[2*i+1];
                    end
                end
            end

            assign pixel_vector_out[t*ACC_W +: ACC_W] = node[1];
        end
    end

endmodule

// File: tb/tb_convolution_25d.sv
// Directed bench for convolution_25d: a Z_DEPTH=4 and a Z_DEPTH=2 instance
// share clock, reset and the counter pixel stream.
module tb_convolution_25d;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   pix4;
    logic [15:0]   pix2;
    logic [1023:0] kernel4;
    logic [511:0]  kernel2;
    logic [63:0]   out4;
    logic [63:0]   out2;

    int unsigned passed = 0;
    int unsigned total  = 0;

`ifdef CONV25D_RELU_EN
    localparam logic [31:0] NEG_Z2 = 32'd0;
    localparam logic [31:0] NEG_Z4 = 32'd0;
`else
    localparam logic [31:0] NEG_Z2 = 32'hFFFFFEB0;  // -336
    localparam logic [31:0] NEG_Z4 = 32'hFFFFFD60;  // -672
`endif

    always #5 clock = ~clock;

    convolution_25d #(
        .NUM_TREES    (2),
        .Z_DEPTH      (4),
        .P_SR_DEPTH   (4),
        .RAM_SR_DEPTH (2),
        .NUM_SR_ROWS  (4),
        .MA_TREE_SIZE (16)
    ) dut4 (
        .clock            (clock),
        .reset            (reset),
        .pixel_vector_in  (pix4),
        .kernel           (kernel4),
        .pixel_vector_out (out4)
    );

    convolution_25d #(
        .NUM_TREES    (2),
        .Z_DEPTH      (2),
        .P_SR_DEPTH   (4),
        .RAM_SR_DEPTH (2),
        .NUM_SR_ROWS  (4),
        .MA_TREE_SIZE (16)
    ) dut2 (
        .clock            (clock),
        .reset            (reset),
        .pixel_vector_in  (pix2),
        .kernel           (kernel2),
        .pixel_vector_out (out2)
    );

    task automatic drive_pixel(input logic [7:0] p);
        pix4 = {4{p}};
        pix2 = {2{p}};
    endtask

    // mode 0: test-plan kernel, mode 1: all +1, mode 2: all -1
    function automatic logic [7:0] weight_for(input int mode, input int z, input int t, input int j);
        int row;
        int col;
        row = j / 4;
        col = j % 4;
        if (mode == 1) return 8'd1;
        if (mode == 2) return 8'hFF;
        if (z == 0 && t == 0) begin
            if (row < 2) return (col < 2) ? 8'd2 : 8'hFF;
            else         return (col < 2) ? 8'hFF : 8'd2;
        end
        if (z == 0 && t == 1) return (col < 2) ? 8'd2 : 8'd3;
        return (t == 0) ? 8'd3 : 8'd4;
    endfunction

    task automatic set_kernels(input int mode);
        for (int z = 0; z < 4; z++) begin
            for (int t = 0; t < 2; t++) begin
                for (int j = 0; j < 16; j++) begin
                    kernel4[((z*2 + t)*16 + j)*8 +: 8] = weight_for(mode, z, t, j);
                    if (z < 2) kernel2[((z*2 + t)*16 + j)*8 +: 8] = weight_for(mode, z, t, j);
                end
            end
        end
    endtask

    // Leaves the bench at a falling edge with reset released and pixel 0
    // driven, so the next rising edge (edge 0) captures pixel 0.
    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        drive_pixel(8'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_kernels(0);
        drive_pixel(8'hAA);
        repeat (3) @(negedge clock);
        total++;
        if (out4 !== 64'd0) $display("FAIL reset_z4: got %h, expected 0", out4);
        else passed++;
        total++;
        if (out2 !== 64'd0) $display("FAIL reset_z2: got %h, expected 0", out2);
        else passed++;
    endtask

    task automatic test_stream();
        int e;
        set_kernels(0);
        apply_reset();
        for (int c = 1; c <= 31; c++) begin
            @(negedge clock);
            e = c - 1;  // outputs now reflect edge e
            if (e == 9) begin  // Z2 fill period, newest pixel 3
                total++;
                if (out2[31:0] !== 32'd27) $display("FAIL fill_z2_t0: got %0d, expected 27", $signed(out2[31:0]));
                else passed++;
                total++;
                if (out2[63:32] !== 32'd37) $display("FAIL fill_z2_t1: got %0d, expected 37", $signed(out2[63:32]));
                else passed++;
            end
            if (e == 10) begin  // Z4 fill period, newest pixel 3
                total++;
                if (out4[31:0] !== 32'd63) $display("FAIL fill_z4_t0: got %0d, expected 63", $signed(out4[31:0]));
                else passed++;
                total++;
                if (out4[63:32] !== 32'd85) $display("FAIL fill_z4_t1: got %0d, expected 85", $signed(out4[63:32]));
                else passed++;
            end
            if (e == 27) begin  // Z2, newest 21
                total++;
                if (out2[31:0] !== 32'd588) $display("FAIL z2_n21_t0: got %0d, expected 588", $signed(out2[31:0]));
                else passed++;
                total++;
                if (out2[63:32] !== 32'd1084) $display("FAIL z2_n21_t1: got %0d, expected 1084", $signed(out2[63:32]));
                else passed++;
            end
            if (e == 28) begin  // Z4 newest 21, Z2 newest 22
                total++;
                if (out4[31:0] !== 32'd1596) $display("FAIL z4_n21_t0: got %0d, expected 1596", $signed(out4[31:0]));
                else passed++;
                total++;
                if (out4[63:32] !== 32'd2428) $display("FAIL z4_n21_t1: got %0d, expected 2428", $signed(out4[63:32]));
                else passed++;
                total++;
                if (out2[31:0] !== 32'd644) $display("FAIL z2_n22_t0: got %0d, expected 644", $signed(out2[31:0]));
                else passed++;
                total++;
                if (out2[63:32] !== 32'd1188) $display("FAIL z2_n22_t1: got %0d, expected 1188", $signed(out2[63:32]));
                else passed++;
            end
            if (e == 29) begin  // Z4 newest 22: t0 = 92 + 3*552, t1 = 452 + 3*736
                total++;
                if (out4[31:0] !== 32'd1748) $display("FAIL z4_n22_t0: got %0d, expected 1748", $signed(out4[31:0]));
                else passed++;
                total++;
                if (out4[63:32] !== 32'd2660) $display("FAIL z4_n22_t1: got %0d, expected 2660", $signed(out4[63:32]));
                else passed++;
            end
            drive_pixel(8'(c));
        end
    endtask

    task automatic test_latency();
        int first4;
        int first2;
        logic [31:0] val4;
        logic [31:0] val2;
        first4 = -1;
        first2 = -1;
        val4 = '0;
        val2 = '0;
        set_kernels(1);
        apply_reset();
        drive_pixel(8'd5);  // single pulse captured at edge 0
        for (int e = 0; e < 20; e++) begin
            @(negedge clock);
            drive_pixel(8'd0);
            if (first4 < 0 && out4[31:0] != 32'd0) begin
                first4 = e;
                val4 = out4[31:0];
            end
            if (first2 < 0 && out2[31:0] != 32'd0) begin
                first2 = e;
                val2 = out2[31:0];
            end
        end
        total++;
        if (first4 != 7) $display("FAIL latency_z4: got edge %0d, expected edge 7", first4);
        else passed++;
        total++;
        if (first2 != 6) $display("FAIL latency_z2: got edge %0d, expected edge 6", first2);
        else passed++;
        total++;
        if (val4 !== 32'd20) $display("FAIL pulse_z4: got %0d, expected 20", val4);
        else passed++;
        total++;
        if (val2 !== 32'd10) $display("FAIL pulse_z2: got %0d, expected 10", val2);
        else passed++;
    endtask

    task automatic test_reset_midstream();
        set_kernels(0);
        apply_reset();
        for (int c = 1; c <= 25; c++) begin
            @(negedge clock);
            drive_pixel(8'(c));
        end
        total++;
        if (out4 === 64'd0) $display("FAIL pre_reset_z4: got %h, expected nonzero", out4);
        else passed++;
        #2;
        reset = 1'b0;
        #1;  // well before the next rising edge
        total++;
        if (out4 !== 64'd0) $display("FAIL async_reset_z4: got %h, expected 0", out4);
        else passed++;
        total++;
        if (out2 !== 64'd0) $display("FAIL async_reset_z2: got %h, expected 0", out2);
        else passed++;
        drive_pixel(8'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            total++;
            if (out4 !== 64'd0) $display("FAIL flush_z4 cycle %0d: got %h, expected 0", k, out4);
            else passed++;
            total++;
            if (out2 !== 64'd0) $display("FAIL flush_z2 cycle %0d: got %h, expected 0", k, out2);
            else passed++;
        end
    endtask

    task automatic test_negative();
        int e;
        set_kernels(2);
        apply_reset();
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            e = c - 1;
            if (e == 27) begin
                total++;
                if (out2[31:0] !== NEG_Z2) $display("FAIL neg_z2_t0: got %h, expected %h", out2[31:0], NEG_Z2);
                else passed++;
                total++;
                if (out2[63:32] !== NEG_Z2) $display("FAIL neg_z2_t1: got %h, expected %h", out2[63:32], NEG_Z2);
                else passed++;
            end
            if (e == 28) begin
                total++;
                if (out4[31:0] !== NEG_Z4) $display("FAIL neg_z4_t0: got %h, expected %h", out4[31:0], NEG_Z4);
                else passed++;
            end
            drive_pixel(8'(c));
        end
    endtask

    initial begin
        reset   = 1'b0;
        pix4    = '0;
        pix2    = '0;
        kernel4 = '0;
        kernel2 = '0;
        test_reset();
        test_stream();
        test_latency();
        test_reset_midstream();
        test_negative();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
